// File: rtl/ann_pkg.sv
// rtl/ann_pkg.sv - shared constants, register map and FSM state type for the neuron accelerator
package ann_pkg;

  localparam int DATA_W    = 16;
  localparam int ACC_W     = 36;
  localparam int DEPTH     = 16;
  localparam int FRAC_BITS = 8;

  localparam logic [5:0] ADDR_CTRL   = 6'd0;
  localparam logic [5:0] ADDR_STATUS = 6'd1;
  localparam logic [5:0] ADDR_LEN    = 6'd2;
  localparam logic [5:0] ADDR_BIAS   = 6'd3;
  localparam logic [5:0] ADDR_RESULT = 6'd4;
  localparam logic [5:0] ADDR_X_BASE = 6'd16;
  localparam logic [5:0] ADDR_W_BASE = 6'd32;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    FIN
  } neuron_state_t;

endpackage

// File: rtl/ann_mac_unit.sv
// rtl/ann_mac_unit.sv - signed Q8.8 multiply-accumulate with Q20.16 accumulator, saturation and ReLU
module ann_mac_unit #(
  parameter int DATA_W = ann_pkg::DATA_W,
  parameter int ACC_W  = ann_pkg::ACC_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic signed [DATA_W-1:0] bias,
  input  logic                     step,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W-1:0] w,
  input  logic                     relu_en,
  output logic signed [DATA_W-1:0] result
);
  import ann_pkg::FRAC_BITS;

  localparam int R_W = ACC_W - FRAC_BITS;
  localparam logic signed [R_W-1:0] SAT_MAX = R_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [R_W-1:0] SAT_MIN = R_W'(-(1 << (DATA_W - 1)));

  logic signed [ACC_W-1:0]    acc;
  logic signed [2*DATA_W-1:0] product;
  logic signed [R_W-1:0]      shifted;
  logic signed [DATA_W-1:0]   sat;
  logic                       unused_frac;

  assign product     = x * w;
  // Dropping the fraction bits is an arithmetic shift that truncates toward minus infinity.
  assign shifted     = acc[ACC_W-1:FRAC_BITS];
  assign unused_frac = ^acc[FRAC_BITS-1:0];

  // Accumulator: bias preload (aligned to Q.16) on start, one product per MAC step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (load) begin
      acc <= {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias} << FRAC_BITS;
    end else if (step) begin
      acc <= acc + {{(ACC_W-2*DATA_W){product[2*DATA_W-1]}}, product};
    end
  end

  // Clamp to the Q8.8 range, then optionally clip negatives to zero.
  always_comb begin
    sat = shifted[DATA_W-1:0];
    if (shifted > SAT_MAX) begin
      sat = SAT_MAX[DATA_W-1:0];
    end else if (shifted < SAT_MIN) begin
      sat = SAT_MIN[DATA_W-1:0];
    end
    result = (relu_en && sat[DATA_W-1]) ? '0 : sat;
  end

endmodule

// File: rtl/ann_neuron_avs.sv
// rtl/ann_neuron_avs.sv - Avalon-MM single-neuron accelerator: register file, operand buffers, sequencing FSM
module ann_neuron_avs #(
  parameter int DEPTH  = ann_pkg::DEPTH,
  parameter int DATA_W = ann_pkg::DATA_W,
  parameter int ACC_W  = ann_pkg::ACC_W
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [5:0]  avs_address,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  output logic        irq
);
  import ann_pkg::*;

  localparam int IDX_W = $clog2(DEPTH);

  neuron_state_t            state;
  logic                     busy;
  logic                     done;
  logic                     relu_en;
  logic                     irq_en;
  logic [4:0]               len;
  logic signed [DATA_W-1:0] bias;
  logic signed [DATA_W-1:0] result;
  logic signed [DATA_W-1:0] x_mem [DEPTH];
  logic signed [DATA_W-1:0] w_mem [DEPTH];
  logic [IDX_W-1:0]         idx;

  logic                     buf_hit;
  logic                     x_sel;
  logic                     w_sel;
  logic [IDX_W-1:0]         buf_ptr;
  logic                     start_acc;
  logic                     status_w1c;
  logic signed [DATA_W-1:0] mac_result;
  logic [31:0]              rd_mux;
  logic                     unused_wdata;

  assign x_sel        = (avs_address[5:4] == ADDR_X_BASE[5:4]);
  assign w_sel        = (avs_address[5:4] == ADDR_W_BASE[5:4]);
  assign buf_hit      = ({1'b0, avs_address[3:0]} < 5'(DEPTH));
  assign buf_ptr      = avs_address[IDX_W-1:0];
  assign start_acc    = avs_write && (avs_address == ADDR_CTRL) && avs_writedata[0] && (state == IDLE);
  assign status_w1c   = avs_write && (avs_address == ADDR_STATUS) && avs_writedata[1];
  assign irq          = done & irq_en;
  assign unused_wdata = ^avs_writedata[31:DATA_W];

  ann_mac_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .load    (start_acc),
    .bias    (bias),
    .step    (state == MAC),
    .x       (x_mem[idx]),
    .w       (w_mem[idx]),
    .relu_en (relu_en),
    .result  (mac_result)
  );

  // Software-writable configuration and operands; frozen while a computation runs.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      relu_en <= 1'b0;
      irq_en  <= 1'b0;
      len     <= '0;
      bias    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        x_mem[i] <= '0;
        w_mem[i] <= '0;
      end
    end else if (avs_write && !busy) begin
      case (avs_address)
        ADDR_CTRL: begin
          relu_en <= avs_writedata[1];
          irq_en  <= avs_writedata[2];
        end
        ADDR_LEN:  len  <= (avs_writedata[4:0] > 5'(DEPTH)) ? 5'(DEPTH) : avs_writedata[4:0];
        ADDR_BIAS: bias <= avs_writedata[DATA_W-1:0];
        default: begin
          if (buf_hit && x_sel) x_mem[buf_ptr] <= avs_writedata[DATA_W-1:0];
          if (buf_hit && w_sel) w_mem[buf_ptr] <= avs_writedata[DATA_W-1:0];
        end
      endcase
    end
  end

  // Sequencer: one MAC step per cycle over LEN entries, then a single FIN cycle latches RESULT.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      idx    <= '0;
      result <= '0;
    end else begin
      if (status_w1c) done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_acc) begin
            idx   <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
            state <= (len != 5'd0) ? MAC : FIN;
          end
        end
        MAC: begin
          idx <= idx + 1'b1;
          if (5'(idx) == len - 5'd1) state <= FIN;
        end
        FIN: begin
          result <= mac_result;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read address decode.
  always_comb begin
    rd_mux = '0;
    case (avs_address)
      ADDR_CTRL:   rd_mux = {29'd0, relu_en, irq_en, 1'b0};
      ADDR_STATUS: rd_mux = {30'd0, done, busy};
      ADDR_LEN:    rd_mux = {27'd0, len};
      ADDR_BIAS:   rd_mux = {{(32-DATA_W){1'b0}}, bias};
      ADDR_RESULT: rd_mux = {{(32-DATA_W){result[DATA_W-1]}}, result};
      default: begin
        if (buf_hit && x_sel) rd_mux = {{(32-DATA_W){1'b0}}, x_mem[buf_ptr]};
        else if (buf_hit && w_sel) rd_mux = {{(32-DATA_W){1'b0}}, w_mem[buf_ptr]};
      end
    endcase
  end

  // Read data register gives the fixed one-cycle read latency.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      avs_readdata <= '0;
    end else if (avs_read) begin
      avs_readdata <= rd_mux;
    end
  end

endmodule
